// File: rtl/boc_trk_pkg.sv
// Shared types and constants for the BOC tracking correlator.
package boc_trk_pkg;

   localparam int ACC_WIDTH_DEF = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } trk_state_e;

   localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
   localparam logic signed [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/boc_corr_arm.sv
// One signed saturating correlator arm: accumulates +/-sample, reloads on load, zeroes on clear.
module boc_corr_arm #(
   parameter int DATA_WIDTH = 24,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic signed [DATA_WIDTH-1:0] sample_i,
   input  logic                         sign_i,
   input  logic                         en_i,
   input  logic                         load_i,
   input  logic                         clear_i,
   output logic signed [ACC_WIDTH-1:0]  sum_o,
   output logic                         sat_o
);

   localparam int EW = ACC_WIDTH + 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
   logic                        sat_q, sat_d;
   logic signed [EW-1:0]        smp_ext, contrib, base, total;

   // The extra guard bit makes overflow visible as a disagreement of the top two bits.
   function automatic logic is_clip(input logic signed [EW-1:0] v);
      return v[EW-1] ^ v[EW-2];
   endfunction

   function automatic logic signed [ACC_WIDTH-1:0] sat_clip(input logic signed [EW-1:0] v);
      if (!is_clip(v))
         return v[ACC_WIDTH-1:0];
      else if (v[EW-1])
         return SAT_MIN;
      else
         return SAT_MAX;
   endfunction

   always_comb begin
      smp_ext = {{(EW-DATA_WIDTH){sample_i[DATA_WIDTH-1]}}, sample_i};
      contrib = sign_i ? smp_ext : -smp_ext;
      base    = load_i ? '0 : {sum_q[ACC_WIDTH-1], sum_q};
      total   = base + contrib;
   end

   always_comb begin
      sum_d = sum_q;
      sat_d = sat_q;
      if (clear_i) begin
         sum_d = '0;
         sat_d = 1'b0;
      end else if (load_i) begin
         sum_d = sat_clip(total);
         sat_d = is_clip(total);
      end else if (en_i) begin
         sum_d = sat_clip(total);
         sat_d = sat_q | is_clip(total);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sum_q <= '0;
         sat_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         sat_q <= sat_d;
      end
   end

   assign sum_o = sum_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/boc_trk_corr.sv
// E/P/L x I/Q tracking correlator: integrates over N PRN periods and dumps via valid/ready.
module boc_trk_corr
   import boc_trk_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int INT_WIDTH  = 5,
   parameter int OVR_WIDTH  = 8
) (
   input  logic                         rx_clk,
   input  logic                         rx_rst_n,
   input  logic                         rx_trk_rst,
   input  logic signed [DATA_WIDTH-1:0] rx_data_real,
   input  logic signed [DATA_WIDTH-1:0] rx_data_imag,
   input  logic                         rx_loc_bocE,
   input  logic                         rx_loc_bocP,
   input  logic                         rx_loc_bocL,
   input  logic                         rx_prn_sop,
   input  logic [INT_WIDTH-1:0]         rx_int_len,
   input  logic                         rx_dump_ready,
   output logic                         tx_dump_valid,
   output logic signed [ACC_WIDTH-1:0]  tx_ie,
   output logic signed [ACC_WIDTH-1:0]  tx_qe,
   output logic signed [ACC_WIDTH-1:0]  tx_ip,
   output logic signed [ACC_WIDTH-1:0]  tx_qp,
   output logic signed [ACC_WIDTH-1:0]  tx_il,
   output logic signed [ACC_WIDTH-1:0]  tx_ql,
   output logic                         tx_dump_sat,
   output logic [OVR_WIDTH-1:0]         tx_ovr_cnt
);

   trk_state_e             state_q, state_d;
   logic [INT_WIDTH-1:0]   epoch_q, epoch_d;
   logic [INT_WIDTH-1:0]   len_q, len_d, len_sel;
   logic                   valid_q, valid_d;
   logic                   dsat_q, dsat_d;
   logic [OVR_WIDTH-1:0]   ovr_q, ovr_d;
   logic signed [ACC_WIDTH-1:0] dump_q [6];
   logic signed [ACC_WIDTH-1:0] dump_d [6];
   logic signed [ACC_WIDTH-1:0] arm_sum [6];
   logic [5:0]             arm_sat;
   logic [2:0]             loc;
   logic                   arm_en, arm_load, dump_evt;

   assign loc = {rx_loc_bocL, rx_loc_bocP, rx_loc_bocE};

   // Arm order: IE, QE, IP, QP, IL, QL (even = I, odd = Q).
   for (genvar g = 0; g < 6; g++) begin : g_arm
      boc_corr_arm #(
         .DATA_WIDTH(DATA_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_arm (
         .clk_i   (rx_clk),
         .rst_ni  (rx_rst_n),
         .sample_i((g % 2 == 0) ? rx_data_real : rx_data_imag),
         .sign_i  (loc[g/2]),
         .en_i    (arm_en),
         .load_i  (arm_load),
         .clear_i (rx_trk_rst),
         .sum_o   (arm_sum[g]),
         .sat_o   (arm_sat[g])
      );
   end

   assign len_sel = (rx_int_len == '0) ? INT_WIDTH'(1) : rx_int_len;

   always_comb begin
      state_d  = state_q;
      epoch_d  = epoch_q;
      len_d    = len_q;
      arm_en   = 1'b0;
      arm_load = 1'b0;
      dump_evt = 1'b0;
      if (rx_trk_rst) begin
         state_d = IDLE;
         epoch_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rx_prn_sop) begin
                  arm_load = 1'b1;
                  epoch_d  = '0;
                  len_d    = len_sel;
                  state_d  = ACCUM;
               end
            end
            ACCUM: begin
               arm_en = 1'b1;
               if (rx_prn_sop) begin
                  if (epoch_q == len_q - INT_WIDTH'(1)) begin
                     dump_evt = 1'b1;
                     arm_load = 1'b1;
                     epoch_d  = '0;
                     len_d    = len_sel;
                  end else begin
                     epoch_d = epoch_q + INT_WIDTH'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A dump that finds the previous result still unconsumed is dropped and counted.
   always_comb begin
      valid_d = valid_q;
      dsat_d  = dsat_q;
      ovr_d   = ovr_q;
      for (int k = 0; k < 6; k++) dump_d[k] = dump_q[k];
      if (rx_trk_rst) begin
         valid_d = 1'b0;
         ovr_d   = '0;
      end else if (dump_evt) begin
         if (!valid_q || rx_dump_ready) begin
            for (int k = 0; k < 6; k++) dump_d[k] = arm_sum[k];
            dsat_d  = |arm_sat;
            valid_d = 1'b1;
         end else if (ovr_q != '1) begin
            ovr_d = ovr_q + OVR_WIDTH'(1);
         end
      end else if (valid_q && rx_dump_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state_q <= IDLE;
         epoch_q <= '0;
         len_q   <= INT_WIDTH'(1);
         valid_q <= 1'b0;
         dsat_q  <= 1'b0;
         ovr_q   <= '0;
         for (int k = 0; k < 6; k++) dump_q[k] <= '0;
      end else begin
         state_q <= state_d;
         epoch_q <= epoch_d;
         len_q   <= len_d;
         valid_q <= valid_d;
         dsat_q  <= dsat_d;
         ovr_q   <= ovr_d;
         for (int k = 0; k < 6; k++) dump_q[k] <= dump_d[k];
      end
   end

   assign tx_dump_valid = valid_q;
   assign tx_ie         = dump_q[0];
   assign tx_qe         = dump_q[1];
   assign tx_ip         = dump_q[2];
   assign tx_qp         = dump_q[3];
   assign tx_il         = dump_q[4];
   assign tx_ql         = dump_q[5];
   assign tx_dump_sat   = dsat_q;
   assign tx_ovr_cnt    = ovr_q;

endmodule

// File: tb/tb_boc_trk_corr.sv
// Scoreboard bench for boc_trk_corr with 16-bit data and 16-bit accumulators.
module tb_boc_trk_corr;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int IW = 5;
   localparam int OW = 8;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  trk_rst;
   logic signed [DW-1:0]  d_re, d_im;
   logic                  loc_e, loc_p, loc_l;
   logic                  sop;
   logic [IW-1:0]         int_len;
   logic                  ready;
   logic                  valid;
   logic signed [AW-1:0]  ie, qe, ip, qp, il, ql;
   logic                  dsat;
   logic [OW-1:0]         ovr;

   typedef struct {
      int ie, qe, ip, qp, il, ql;
      bit sat;
   } exp_t;

   exp_t q_exp[$];
   exp_t mon_e;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   boc_trk_corr #(
      .DATA_WIDTH(DW),
      .ACC_WIDTH (AW),
      .INT_WIDTH (IW),
      .OVR_WIDTH (OW)
   ) dut (
      .rx_clk       (clk),
      .rx_rst_n     (rst_n),
      .rx_trk_rst   (trk_rst),
      .rx_data_real (d_re),
      .rx_data_imag (d_im),
      .rx_loc_bocE  (loc_e),
      .rx_loc_bocP  (loc_p),
      .rx_loc_bocL  (loc_l),
      .rx_prn_sop   (sop),
      .rx_int_len   (int_len),
      .rx_dump_ready(ready),
      .tx_dump_valid(valid),
      .tx_ie        (ie),
      .tx_qe        (qe),
      .tx_ip        (ip),
      .tx_qp        (qp),
      .tx_il        (il),
      .tx_ql        (ql),
      .tx_dump_sat  (dsat),
      .tx_ovr_cnt   (ovr)
   );

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic push(input int e_i, input int e_q, input int p_i, input int p_q,
                       input int l_i, input int l_q, input bit s);
      exp_t e;
      e.ie = e_i; e.qe = e_q; e.ip = p_i; e.qp = p_q; e.il = l_i; e.ql = l_q; e.sat = s;
      q_exp.push_back(e);
   endtask

   task automatic smp(input bit s, input int dr, input int di, input bit e, input bit p, input bit l);
      sop   = s;
      d_re  = DW'(dr);
      d_im  = DW'(di);
      loc_e = e;
      loc_p = p;
      loc_l = l;
      @(posedge clk);
      #1;
   endtask

   task automatic period(input int n, input int dr, input int di,
                         input logic [31:0] ep, input logic [31:0] pp, input logic [31:0] lp);
      for (int k = 0; k < n; k++) smp(k == 0, dr, di, ep[k], pp[k], lp[k]);
   endtask

   // Monitor: every accepted dump is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         total++;
         if (q_exp.size() == 0) begin
            $display("FAIL unexpected_dump: got ip=%0d ie=%0d il=%0d, required no dump", ip, ie, il);
         end else begin
            mon_e = q_exp.pop_front();
            if (ie == mon_e.ie && qe == mon_e.qe && ip == mon_e.ip && qp == mon_e.qp &&
                il == mon_e.il && ql == mon_e.ql && dsat == mon_e.sat)
               passed++;
            else
               $display("FAIL dump_data: got ie=%0d qe=%0d ip=%0d qp=%0d il=%0d ql=%0d sat=%0d, required ie=%0d qe=%0d ip=%0d qp=%0d il=%0d ql=%0d sat=%0d",
                        ie, qe, ip, qp, il, ql, dsat,
                        mon_e.ie, mon_e.qe, mon_e.ip, mon_e.qp, mon_e.il, mon_e.ql, mon_e.sat);
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      trk_rst = 1'b0;
      d_re    = '0;
      d_im    = '0;
      loc_e   = 1'b1;
      loc_p   = 1'b1;
      loc_l   = 1'b1;
      sop     = 1'b0;
      int_len = 5'd1;
      ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_valid", valid, 0);
      chk("reset_ip", ip, 0);
      chk("reset_sat", dsat, 0);
      chk("reset_ovr", ovr, 0);

      // Basic dump, int_len = 1
      period(4, 100, -50, '1, '1, '1);
      chk("valid_before_first_dump", valid, 0);
      push(400, -200, 400, -200, 400, -200, 0);
      smp(1, 100, -50, 1, 1, 1);
      chk("valid_after_2nd_sop", valid, 1);
      chk("latency_ip", ip, 400);
      repeat (3) smp(0, 100, -50, 1, 1, 1);
      push(400, -200, 400, -200, 400, -200, 0);

      // Replica sign: E=-1, P=+1, L alternating
      period(4, 10, 0, 32'h0, 32'hF, 32'h5);
      push(-40, 0, 40, 0, 0, 0, 0);

      // Multi-epoch integration, int_len = 3
      int_len = 5'd3;
      period(5, 7, 0, '1, '1, '1);
      smp(1, 7, 0, 1, 1, 1);
      chk("no_dump_mid_interval", valid, 0);
      repeat (4) smp(0, 7, 0, 1, 1, 1);
      period(5, 7, 0, '1, '1, '1);
      push(105, 0, 105, 0, 105, 0, 0);
      repeat (3) period(5, 7, 0, '1, '1, '1);
      push(105, 0, 105, 0, 105, 0, 0);

      // int_len = 0 acts as 1
      int_len = 5'd0;
      period(5, 7, 0, '1, '1, '1);
      push(35, 0, 35, 0, 35, 0, 0);
      period(5, 7, 0, '1, '1, '1);
      push(35, 0, 35, 0, 35, 0, 0);

      // Saturation, then a clean interval
      period(5, 8000, -8000, '1, '1, '1);
      push(32767, -32768, 32767, -32768, 32767, -32768, 1);
      period(4, 1, 1, '1, '1, '1);
      push(4, 4, 4, 4, 4, 4, 0);

      // Backpressure across three dump events
      ready = 1'b0;
      period(4, 2, 0, '1, '1, '1);
      chk("bp_valid_held", valid, 1);
      period(4, 5, 0, '1, '1, '1);
      chk("bp_ovr_1", ovr, 1);
      period(4, 3, 0, '1, '1, '1);
      chk("bp_ovr_2", ovr, 2);
      chk("bp_first_result_held", ip, 4);
      push(12, 0, 12, 0, 12, 0, 0);
      ready = 1'b1;
      smp(1, 6, 0, 1, 1, 1);
      chk("bp_valid_stays", valid, 1);
      chk("bp_new_loaded", ip, 12);
      repeat (3) smp(0, 6, 0, 1, 1, 1);

      // Tracking restart mid-interval, sop in the same cycle ignored
      ready = 1'b0;
      smp(1, 7, 0, 1, 1, 1);
      smp(0, 7, 0, 1, 1, 1);
      trk_rst = 1'b1;
      smp(1, 7, 0, 1, 1, 1);
      trk_rst = 1'b0;
      chk("trk_rst_valid", valid, 0);
      chk("trk_rst_ovr", ovr, 0);
      chk("trk_rst_data_kept", ip, 24);
      ready = 1'b1;
      repeat (2) smp(0, 99, 99, 1, 1, 1);
      period(4, 9, 0, '1, '1, '1);
      ready = 1'b0;
      smp(1, 1, 0, 1, 1, 1);
      chk("fresh_valid", valid, 1);
      chk("fresh_ip", ip, 36);
      chk("fresh_ie", ie, 36);
      chk("fresh_sat", dsat, 0);
      repeat (3) smp(0, 1, 0, 1, 1, 1);
      smp(1, 1, 0, 1, 1, 1);
      chk("post_rst_ovr", ovr, 1);
      chk("scoreboard_drained", q_exp.size(), 0);

      // Asynchronous reset between clock edges
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", valid, 0);
      chk("async_ip", ip, 0);
      chk("async_ovr", ovr, 0);
      chk("async_sat", dsat, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/boc_trk_corr.md
Name: boc_trk_corr

Overview:
- Tracking-loop correlator directly downstream of the B1 BOC acquisition/local-replica stage.
- Consumes carrier-wiped baseband I/Q samples, the Early/Prompt/Late BOC replica bits, the PRN start-of-period strobe and the tracking reset.
- Integrates E/P/L in I and Q over a programmable number of PRN periods, then dumps six saturated sums to the loop discriminator through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 24: signed width of rx_data_real/rx_data_imag (16x8 mixer product).
- ACC_WIDTH, 32: signed accumulator and dump width.
- INT_WIDTH, 5: width of rx_int_len.
- OVR_WIDTH, 8: width of the overrun counter.

Ports:
- rx_clk  in  1  sample clock, one sample per cycle.
- rx_rst_n  in  1  reset, asynchronous, active-low.
- rx_trk_rst  in  1  synchronous tracking restart (from acquisition).
- rx_data_real  in  DATA_WIDTH  signed baseband I sample.
- rx_data_imag  in  DATA_WIDTH  signed baseband Q sample.
- rx_loc_bocE / rx_loc_bocP / rx_loc_bocL  in  1 each  replica chip; 1 = +1, 0 = -1.
- rx_prn_sop  in  1  high on the first sample of a PRN period.
- rx_int_len  in  INT_WIDTH  PRN periods per dump; 0 is treated as 1.
- rx_dump_ready  in  1  consumer accepts the dump.
- tx_dump_valid  out  1  dump registers hold an unconsumed result.
- tx_ie, tx_qe, tx_ip, tx_qp, tx_il, tx_ql  out  ACC_WIDTH each  signed integrated correlations.
- tx_dump_sat  out  1  at least one accumulator clamped during this dump interval.
- tx_ovr_cnt  out  OVR_WIDTH  dumps dropped because the consumer was not ready; saturating.

Behaviour:
- Async reset (rx_rst_n = 0): state IDLE; all accumulators, dump outputs, tx_dump_valid, tx_dump_sat, tx_ovr_cnt and the epoch counter are 0.
- Contribution per cycle: X = data if loc bit = 1, otherwise -data. Sign-extend data to ACC_WIDTH+1 before add/subtract.
- Saturation: clamp the sum to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Any clamp sets a sticky sat_acc bit for the current interval.
- FSM IDLE: ignore samples until rx_prn_sop = 1. On that cycle:
  - load each accumulator with the current sample's contribution;
  - set epoch_cnt = 0;
  - latch int_len = max(rx_int_len, 1);
  - go to ACCUM.
- FSM ACCUM, rx_prn_sop = 0: accumulate the current sample.
- FSM ACCUM, rx_prn_sop = 1 and epoch_cnt < int_len-1: increment epoch_cnt and accumulate the current sample.
- FSM ACCUM, rx_prn_sop = 1 and epoch_cnt == int_len-1 (dump event):
  - the dump contents are the accumulator values excluding the current sample;
  - reload the accumulators with the current contribution, set epoch_cnt = 0, re-latch int_len, clear sat_acc.
- Latency: dump outputs and tx_dump_valid update on the clock edge that samples the dump-event sop, i.e. they are visible the following cycle.
- Handshake: a transfer occurs when tx_dump_valid && rx_dump_ready. Outputs stay stable while valid && !ready.
  - Dump event with valid = 0: load outputs, set valid = 1.
  - Dump event with valid = 1 and ready = 1: the old result transfers this cycle, the new one loads, valid stays 1.
  - Dump event with valid = 1 and ready = 0: discard the new result, keep the old one, tx_ovr_cnt += 1 (saturates at all-ones).
  - No dump event, valid && ready: valid goes to 0.
- rx_trk_rst = 1 (synchronous, highest priority after rx_rst_n):
  - forces IDLE and clears accumulators, epoch_cnt, sat_acc, tx_dump_valid and tx_ovr_cnt;
  - dump data registers keep their values;
  - a sop in the same cycle is ignored; accumulation resumes on the next sop after rx_trk_rst deasserts.
- rx_int_len changes mid-interval take effect only at the next dump or IDLE exit.

Decomposition:
- Package boc_trk_pkg:
  - ACC_WIDTH default;
  - state enum {IDLE, ACCUM};
  - saturation bound constants ACC_MAX/ACC_MIN.
- Sub-module boc_corr_arm: one signed, saturating accumulate-and-reload arm with inputs sample, sign bit, load, clear and outputs sum, sat. Instantiated six times (E/P/L x I/Q).
- FSM, epoch counter, dump registers and handshake live in the top module.

Test Plan:
- Basic dump: int_len = 1, 4-sample PRN period, data_real = +100, data_imag = -50, all loc bits = 1, sop every 4 cycles.
  - First dump appears one cycle after the 2nd sop.
  - tx_ip = 400, tx_qp = -200, likewise E/L; tx_dump_sat = 0.
- Replica sign: loc bocE = 0, bocP = 1, bocL alternating 1,0,1,0, data_real = +10.
  - tx_ie = -40, tx_ip = 40, tx_il = 0.
- Multi-epoch integration: int_len = 3, constant data +7, period 5.
  - Dumps every 15 cycles, each tx_ip = 105.
  - int_len = 0 behaves as 1: dumps every 5 cycles.
- Saturation: ACC_WIDTH = 16, data = +8000, long period.
  - tx_ip = 32767 and tx_dump_sat = 1.
  - Next interval with small data gives tx_dump_sat = 0.
- Backpressure: rx_dump_ready = 0 across 3 dump events.
  - First result is held; tx_ovr_cnt = 2.
  - Then ready = 1 coincident with a 4th dump: old result transfers, new one loads, valid stays 1.
- Reset mid-interval:
  - rx_trk_rst pulsed mid-accumulation: valid = 0, ovr = 0; the sop in the same cycle is ignored; the next full dump equals a fresh interval.
  - rx_rst_n asserted asynchronously mid-cycle: all outputs 0 immediately.
